// File: rtl/sipo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sipo_ctrl
// Brief    : Serial-in/parallel-out packer. Collects DEPTH beats (or fewer on
//            flush) into one word and holds it under a valid/ready handshake.
// Revision : 1.0  initial release
// ============================================================================
module sipo_ctrl #(
    parameter  int SERIAL_WIDTH   = 8,
    parameter  int DEPTH          = 5,
    parameter  int LEFT_SHIFT     = 1,
    localparam int PARALLEL_WIDTH = SERIAL_WIDTH * DEPTH,
    localparam int CW             = $clog2(DEPTH + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [SERIAL_WIDTH-1:0]   data_in,
    input  logic                      data_in_valid,
    output logic                      data_in_ready,
    input  logic                      flush_i,
    output logic [PARALLEL_WIDTH-1:0] data_out,
    output logic                      data_out_valid,
    input  logic                      data_out_ready,
    output logic [CW-1:0]             data_out_count
);

    localparam logic [CW-1:0] c_last = CW'(DEPTH - 1);
    localparam logic [CW-1:0] c_one  = CW'(1);

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [PARALLEL_WIDTH-1:0] r_buf;
    logic [PARALLEL_WIDTH-1:0] w_buf_nxt;
    logic [CW-1:0]             r_cnt;
    logic [CW-1:0]             w_cnt_nxt;
    logic [CW-1:0]             w_idx;
    logic [CW-1:0]             w_slot;
    logic                      w_accept;

    // In HOLD, an accepted beat restarts the next word, so it is always beat 0.
    assign data_in_ready  = ~rst_i & ((r_state == S_FILL) | data_out_ready);
    assign w_accept       = data_in_valid & data_in_ready;
    assign data_out_valid = (r_state == S_HOLD);
    assign data_out       = (r_state == S_HOLD) ? r_buf : '0;
    assign data_out_count = (r_state == S_HOLD) ? r_cnt : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_buf_nxt   = r_buf;
        w_cnt_nxt   = r_cnt;
        w_idx       = (r_state == S_HOLD) ? '0 : r_cnt;
        w_slot      = (LEFT_SHIFT != 0) ? (c_last - w_idx) : w_idx;

        if (r_state == S_FILL) begin
            if (w_accept) begin
                w_buf_nxt[w_slot*SERIAL_WIDTH +: SERIAL_WIDTH] = data_in;
                w_cnt_nxt = r_cnt + c_one;
                if ((r_cnt == c_last) || flush_i) begin
                    w_state_nxt = S_HOLD;
                end
            end else if (flush_i && (r_cnt != '0)) begin
                w_state_nxt = S_HOLD;
            end
        end else begin
            if (data_out_ready) begin
                w_state_nxt = S_FILL;
                w_buf_nxt   = '0;
                w_cnt_nxt   = '0;
                if (w_accept) begin
                    w_buf_nxt[w_slot*SERIAL_WIDTH +: SERIAL_WIDTH] = data_in;
                    w_cnt_nxt = c_one;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_FILL;
            r_buf   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_buf   <= w_buf_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sipo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sipo_ctrl
// Brief    : Self-checking bench for sipo_ctrl; both packing orders side by side.
// Revision : 1.0  initial release
// ============================================================================
module tb_sipo_ctrl;

    localparam int SW = 8;
    localparam int DP = 5;
    localparam int PW = SW * DP;
    localparam int CW = $clog2(DP + 1);

    typedef struct {
        logic [PW-1:0] d;
        logic [CW-1:0] c;
    } exp_t;

    typedef struct {
        int              n;
        logic [4:0][7:0] b;
        logic            fl;
        logic [PW-1:0]   exp_l;
        logic [PW-1:0]   exp_r;
        logic [CW-1:0]   cnt;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [SW-1:0] din = '0;
    logic          din_vld = 1'b0;
    logic          flush = 1'b0;
    logic          dout_rdy = 1'b0;
    logic          rand_rdy = 1'b0;

    logic          rdy_l, rdy_r, vld_l, vld_r;
    logic [PW-1:0] dout_l, dout_r;
    logic [CW-1:0] cnt_l, cnt_r;

    exp_t q_l[$];
    exp_t q_r[$];
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    sipo_ctrl #(.SERIAL_WIDTH(SW), .DEPTH(DP), .LEFT_SHIFT(1)) u_dut_l (
        .clk_i(clk), .rst_i(rst), .data_in(din), .data_in_valid(din_vld),
        .data_in_ready(rdy_l), .flush_i(flush), .data_out(dout_l),
        .data_out_valid(vld_l), .data_out_ready(dout_rdy), .data_out_count(cnt_l)
    );

    sipo_ctrl #(.SERIAL_WIDTH(SW), .DEPTH(DP), .LEFT_SHIFT(0)) u_dut_r (
        .clk_i(clk), .rst_i(rst), .data_in(din), .data_in_valid(din_vld),
        .data_in_ready(rdy_r), .flush_i(flush), .data_out(dout_r),
        .data_out_valid(vld_r), .data_out_ready(dout_rdy), .data_out_count(cnt_r)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PW-1:0] pack(input logic [4:0][7:0] bs, input int n, input bit left);
        logic [PW-1:0] w;
        w = '0;
        for (int k = 0; k < n; k++) begin
            if (left) w[(DP-1-k)*SW +: SW] = bs[k];
            else      w[k*SW +: SW]        = bs[k];
        end
        return w;
    endfunction

    function automatic exp_t mk(input logic [PW-1:0] d, input logic [CW-1:0] c);
        exp_t e;
        e.d = d;
        e.c = c;
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic drive_beat(input logic [7:0] b, input logic fl);
        logic acc;
        int   guard;
        din     = b;
        din_vld = 1'b1;
        flush   = fl;
        acc     = 1'b0;
        guard   = 0;
        while (!acc && guard < 60) begin
            if (rand_rdy) dout_rdy = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = rdy_l;
            step();
            guard++;
        end
        if (!acc) chk("accept_timeout", 64'(guard), 64'(0));
        din_vld = 1'b0;
        flush   = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (vld_l && dout_rdy) begin
                if (q_l.size() == 0) chk("unexpected_word_l", 64'(dout_l), 64'(0));
                else begin
                    exp_t e;
                    e = q_l.pop_front();
                    chk("word_l", 64'(dout_l), 64'(e.d));
                    chk("count_l", 64'(cnt_l), 64'(e.c));
                end
            end
            if (vld_r && dout_rdy) begin
                if (q_r.size() == 0) chk("unexpected_word_r", 64'(dout_r), 64'(0));
                else begin
                    exp_t e;
                    e = q_r.pop_front();
                    chk("word_r", 64'(dout_r), 64'(e.d));
                    chk("count_r", 64'(cnt_r), 64'(e.c));
                end
            end
        end
    end

    initial begin
        vec_t            vecs[5];
        logic [4:0][7:0] bs;

        vecs[0] = '{5, {8'h55, 8'h44, 8'h33, 8'h22, 8'h11}, 1'b0, 40'h1122334455, 40'h5544332211, 3'd5};
        vecs[1] = '{3, {8'h00, 8'h00, 8'hCC, 8'hBB, 8'hAA}, 1'b1, 40'hAABBCC0000, 40'h0000CCBBAA, 3'd3};
        vecs[2] = '{5, {8'h05, 8'h04, 8'h03, 8'h02, 8'h01}, 1'b1, 40'h0102030405, 40'h0504030201, 3'd5};
        vecs[3] = '{1, {8'h00, 8'h00, 8'h00, 8'h00, 8'h7E}, 1'b1, 40'h7E00000000, 40'h000000007E, 3'd1};
        vecs[4] = '{4, {8'h00, 8'hF4, 8'hF3, 8'hF2, 8'hF1}, 1'b1, 40'hF1F2F3F400, 40'h00F4F3F2F1, 3'd4};

        // Reset state, with a beat offered that must be ignored
        din = 8'h99; din_vld = 1'b1; dout_rdy = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_in_ready", 64'({rdy_l, rdy_r}), 64'(0));
            chk("rst_valid", 64'({vld_l, vld_r}), 64'(0));
            chk("rst_dout", 64'(dout_l | dout_r), 64'(0));
            chk("rst_count", 64'({cnt_l, cnt_r}), 64'(0));
            step();
        end
        rst = 1'b0; din_vld = 1'b0;
        @(negedge clk);
        chk("idle_valid", 64'({vld_l, vld_r}), 64'(0));
        chk("fill_in_ready", 64'({rdy_l, rdy_r}), 64'(3));
        step();

        for (int i = 0; i < 5; i++) begin
            q_l.push_back(mk(vecs[i].exp_l, vecs[i].cnt));
            q_r.push_back(mk(vecs[i].exp_r, vecs[i].cnt));
            for (int k = 0; k < vecs[i].n; k++)
                drive_beat(vecs[i].b[k], vecs[i].fl && (k == vecs[i].n - 1));
            @(negedge clk);
            chk("latency_valid", 64'({vld_l, vld_r}), 64'(3));
            chk("latency_count", 64'(cnt_l), 64'(vecs[i].cnt));
            step();
            @(negedge clk);
            chk("valid_one_cycle", 64'({vld_l, vld_r}), 64'(0));
            step();
            if (i == 1) begin
                flush = 1'b1;
                step();
                flush = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("lone_flush_no_out", 64'({vld_l, vld_r}), 64'(0));
                    step();
                end
            end
        end

        // Backpressure while held; the beat offered on release starts the next word
        dout_rdy = 1'b0;
        q_l.push_back(mk(40'h0102030405, 3'd5));
        q_r.push_back(mk(40'h0504030201, 3'd5));
        for (int k = 1; k <= 5; k++) drive_beat(8'(k), 1'b0);
        din = 8'h66; din_vld = 1'b1; flush = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("hold_in_ready", 64'({rdy_l, rdy_r}), 64'(0));
            chk("hold_dout_l", 64'(dout_l), 64'h0102030405);
            chk("hold_dout_r", 64'(dout_r), 64'h0504030201);
            chk("hold_count", 64'(cnt_r), 64'(5));
            step();
        end
        flush = 1'b0;
        dout_rdy = 1'b1;
        q_l.push_back(mk(40'h66778899AA, 3'd5));
        q_r.push_back(mk(40'hAA99887766, 3'd5));
        @(negedge clk);
        chk("release_in_ready", 64'({rdy_l, rdy_r}), 64'(3));
        step();
        din_vld = 1'b0;
        drive_beat(8'h77, 1'b0);
        drive_beat(8'h88, 1'b0);
        drive_beat(8'h99, 1'b0);
        drive_beat(8'hAA, 1'b0);
        repeat (2) step();

        // Reset mid-word discards the partial word
        drive_beat(8'hE1, 1'b0);
        drive_beat(8'hE2, 1'b0);
        drive_beat(8'hE3, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_zero", 64'(dout_l | dout_r), 64'(0));
        step();
        rst = 1'b0;
        q_l.push_back(mk(40'h0102030405, 3'd5));
        q_r.push_back(mk(40'h0504030201, 3'd5));
        for (int k = 1; k <= 5; k++) drive_beat(8'(k), 1'b0);
        repeat (2) step();

        // Reset while a word is held discards it
        dout_rdy = 1'b0;
        for (int k = 0; k < 5; k++) drive_beat(8'hD0 + 8'(k), 1'b0);
        @(negedge clk);
        chk("held_before_rst", 64'({vld_l, vld_r}), 64'(3));
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        dout_rdy = 1'b1;
        @(negedge clk);
        chk("held_discarded", 64'({vld_l, vld_r}), 64'(0));
        step();

        // 20-beat stream with random output backpressure
        rand_rdy = 1'b1;
        for (int w = 0; w < 4; w++) begin
            for (int k = 0; k < 5; k++) bs[k] = 8'($urandom_range(0, 255));
            q_l.push_back(mk(pack(bs, 5, 1'b1), 3'd5));
            q_r.push_back(mk(pack(bs, 5, 1'b0), 3'd5));
            for (int k = 0; k < 5; k++) drive_beat(bs[k], 1'b0);
        end
        rand_rdy = 1'b0;
        dout_rdy = 1'b1;
        repeat (4) step();

        chk("queue_l_drained", 64'(q_l.size()), 64'(0));
        chk("queue_r_drained", 64'(q_r.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
